// File: rtl/hlsm_param_sched.sv
// ----------------------------------------------------------------------------
// hlsm_param_sched
//   Multi-cycle scheduled datapath for the d/e/f/g/h compare-select-shift
//   kernel, with a Start/Done/Busy handshake. The operands are latched when
//   Start is accepted. The results x/z are held between runs.
//
//   Schedule (one state per cycle):
//     sWait : accept Start, latch a/b/c
//     S1    : d = a+b, e = a+c, f = a-b          (wrap mod 2^DATAWIDTH)
//     S2    : dLTe = (d < e) signed, dEQe = (d == e)
//     S3    : g = dLTe ? d : e
//     S4    : h = dEQe ? g : f, xi = g << dLTe
//     S5    : zi = h >> dEQe (logical or arithmetic per SHIFT_MODE)
//     sFinal: publish x/z, pulse Done
//
// Parameters
//   DATAWIDTH  : data width of a/b/c/x/z and the internal registers (>= 2)
//   SHIFT_MODE : 0 = logical right shift for z, 1 = arithmetic
//
// Optional feature
//   HLSM_OVF_EN : when defined, adds output Ovf. Ovf flags a signed overflow
//                 in any of d/e/f for the run. It is published with x/z.
//
// Ports
//   Clk    in   rising-edge clock
//   Rst    in   asynchronous active-low reset
//   Start  in   launch request, sampled only in sWait
//   a,b,c  in   signed operands
//   Busy   out  high from the cycle after Start is accepted until Done falls
//   Done   out  one-cycle pulse, x/z updated on the same edge
//   x      out  g << dLTe
//   z      out  h >> dEQe
//   Ovf    out  (HLSM_OVF_EN only) overflow flag for the last completed run
// ----------------------------------------------------------------------------
module hlsm_param_sched #(
    parameter int DATAWIDTH  = 32,
    parameter int SHIFT_MODE = 0
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic                        Start,
    input  logic signed [DATAWIDTH-1:0] a,
    input  logic signed [DATAWIDTH-1:0] b,
    input  logic signed [DATAWIDTH-1:0] c,
    output logic                        Busy,
    output logic                        Done,
    output logic signed [DATAWIDTH-1:0] x,
    output logic signed [DATAWIDTH-1:0] z
`ifdef HLSM_OVF_EN
    ,
    output logic                        Ovf
`endif
);

    localparam int MSB = DATAWIDTH - 1;

    typedef enum logic [2:0] {
        sWait  = 3'd0,
        S1     = 3'd1,
        S2     = 3'd2,
        S3     = 3'd3,
        S4     = 3'd4,
        S5     = 3'd5,
        sFinal = 3'd6
    } state_t;

    // Operand copy taken at the accepting edge. The live inputs are
    // don't-care after that edge.
    typedef struct packed {
        logic signed [DATAWIDTH-1:0] ra;
        logic signed [DATAWIDTH-1:0] rb;
        logic signed [DATAWIDTH-1:0] rc;
    } opnd_t;

    state_t                      state;
    opnd_t                       op;
    logic signed [DATAWIDTH-1:0] d, e, f, g, h, xi, zi;
    logic                        dLTe, dEQe;

    // S1 arithmetic. These are kept combinational so the overflow detect
    // can look at the same sums that get registered into d/e/f.
    logic signed [DATAWIDTH-1:0] sum_ab, sum_ac, dif_ab;
    assign sum_ab = op.ra + op.rb;
    assign sum_ac = op.ra + op.rc;
    assign dif_ab = op.ra - op.rb;

    // S5 shift. The shift type is fixed at elaboration. h is signed, so
    // >>> replicates the sign bit and >> fills with zero.
    logic signed [DATAWIDTH-1:0] z_shift;
    generate
        if (SHIFT_MODE != 0) begin : g_ashr
            assign z_shift = h >>> dEQe;
        end else begin : g_lshr
            assign z_shift = h >> dEQe;
        end
    endgenerate

`ifdef HLSM_OVF_EN
    // Two's-complement overflow from the sign bits.
    // An add overflows when both operands have the same sign and the result
    // sign differs. A subtract overflows when the operand signs differ and
    // the result sign differs from the minuend.
    logic ovf_s1;
    logic ovf_r;
    assign ovf_s1 = ((op.ra[MSB] == op.rb[MSB]) && (sum_ab[MSB] != op.ra[MSB]))
                 || ((op.ra[MSB] == op.rc[MSB]) && (sum_ac[MSB] != op.ra[MSB]))
                 || ((op.ra[MSB] != op.rb[MSB]) && (dif_ab[MSB] != op.ra[MSB]));
`endif

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= sWait;
            op    <= '0;
            d     <= '0;
            e     <= '0;
            f     <= '0;
            g     <= '0;
            h     <= '0;
            xi    <= '0;
            zi    <= '0;
            dLTe  <= 1'b0;
            dEQe  <= 1'b0;
            x     <= '0;
            z     <= '0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
`ifdef HLSM_OVF_EN
            ovf_r <= 1'b0;
            Ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                sWait: begin
                    Done <= 1'b0;
                    // Busy is still high here during the Done cycle. A new
                    // Start in that cycle keeps Busy high, so a held Start
                    // launches one run every 7 cycles.
                    if (Start) begin
                        op.ra <= a;
                        op.rb <= b;
                        op.rc <= c;
                        Busy  <= 1'b1;
                        state <= S1;
                    end else begin
                        Busy  <= 1'b0;
                    end
                end
                S1: begin
                    d     <= sum_ab;
                    e     <= sum_ac;
                    f     <= dif_ab;
`ifdef HLSM_OVF_EN
                    ovf_r <= ovf_s1;
`endif
                    state <= S2;
                end
                S2: begin
                    dLTe  <= (d < e);
                    dEQe  <= (d == e);
                    state <= S3;
                end
                S3: begin
                    g     <= dLTe ? d : e;
                    state <= S4;
                end
                S4: begin
                    h     <= dEQe ? g : f;
                    // The shifted-out MSB is dropped.
                    xi    <= g << dLTe;
                    state <= S5;
                end
                S5: begin
                    zi    <= z_shift;
                    state <= sFinal;
                end
                sFinal: begin
                    x     <= xi;
                    z     <= zi;
`ifdef HLSM_OVF_EN
                    Ovf   <= ovf_r;
`endif
                    Done  <= 1'b1;
                    state <= sWait;
                end
                default: begin
                    state <= sWait;
                end
            endcase
        end
    end

endmodule
